// File: rtl/mips_pkg.sv
// Shared constants for the MIPS storage block: default widths, the hard-wired
// zero register index and the byte-to-word address shift.
package mips_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MEM_ADDR_W = 10;
    localparam int DEF_RF_ADDR_W  = 5;

    // Register 0 always reads as zero and ignores writes.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Byte addresses are turned into word indices by dropping the low two bits.
    localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/word_mem.sv
// Word-organised storage with a combinational read port and a clocked write
// port. The array has no reset, so its contents survive reset and uninitialised
// words read as X in simulation. The array is named mem so contents can be
// preloaded hierarchically by a bench.
module word_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Store the incoming word at the rising edge when the write enable is set.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/async_mem_reg_file.sv
// Storage block for the pipelined MIPS core: a word memory with asynchronous
// read / synchronous write, plus a 32x32 register file with two combinational
// read ports and one clocked write port. Reset is synchronous and active-low;
// it clears the registers and blocks memory writes but leaves memory intact.
// Optional build macro RF_BYPASS_EN: a register read port whose index matches
// the register being written this cycle returns the write data directly.
module async_mem_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MEM_ADDR_W = DEF_MEM_ADDR_W,
    parameter int RF_ADDR_W  = DEF_RF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_write,
    input  logic [31:0]          mem_address,
    input  logic [DATA_W-1:0]    mem_write_data,
    output logic [DATA_W-1:0]    mem_read_data,
    input  logic                 rf_write,
    input  logic [RF_ADDR_W-1:0] rf_wr,
    input  logic [DATA_W-1:0]    rf_wd,
    input  logic [RF_ADDR_W-1:0] rf_rr1,
    input  logic [RF_ADDR_W-1:0] rf_rr2,
    output logic [DATA_W-1:0]    rf_rd1,
    output logic [DATA_W-1:0]    rf_rd2
);

    localparam int RF_DEPTH = 1 << RF_ADDR_W;
    localparam logic [RF_ADDR_W-1:0] RF_ZERO = RF_ADDR_W'(REG_ZERO);

    logic                  mem_we;
    logic [MEM_ADDR_W-1:0] mem_word_addr;
    logic                  unused_addr_bits;

    // Memory writes are blocked while reset is held low.
    assign mem_we = mem_write & reset;

    // Low bits select a byte within the word and high bits wrap, so both are dropped.
    assign mem_word_addr    = mem_address[MEM_ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    assign unused_addr_bits = ^{mem_address[31:MEM_ADDR_W+WORD_SHIFT],
                                mem_address[WORD_SHIFT-1:0]};

    word_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .addr  (mem_word_addr),
        .wdata (mem_write_data),
        .rdata (mem_read_data)
    );

    logic [DATA_W-1:0] regs_q [RF_DEPTH];
    logic [DATA_W-1:0] regs_d [RF_DEPTH];

    // Next register contents: a single write per cycle, never to register 0.
    always_comb begin
        regs_d = regs_q;
        if (rf_write && (rf_wr != RF_ZERO)) begin
            regs_d[rf_wr] = rf_wd;
        end
    end

    // Register storage; reset wins over any write in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: index 0 is forced to zero, optionally forwarding this cycle's write.
    always_comb begin
        rf_rd1 = (rf_rr1 == RF_ZERO) ? '0 : regs_q[rf_rr1];
        rf_rd2 = (rf_rr2 == RF_ZERO) ? '0 : regs_q[rf_rr2];
`ifdef RF_BYPASS_EN
        if (rf_write && (rf_wr != RF_ZERO) && (rf_wr == rf_rr1)) begin
            rf_rd1 = rf_wd;
        end
        if (rf_write && (rf_wr != RF_ZERO) && (rf_wr == rf_rr2)) begin
            rf_rd2 = rf_wd;
        end
`endif
    end

endmodule

// File: tb/tb_async_mem_reg_file.sv
// Self-checking bench for async_mem_reg_file: directed scenarios followed by
// randomized traffic compared against a behavioural model built from plain
// arrays. Honours RF_BYPASS_EN the same way as the design build.
module tb_async_mem_reg_file;

    logic        clk;
    logic        reset;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        rf_write;
    logic [4:0]  rf_wr;
    logic [31:0] rf_wd;
    logic [4:0]  rf_rr1;
    logic [4:0]  rf_rr2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;

    int check_count;
    int error_count;

    // Behavioural model: plain register and memory arrays with a valid map for memory.
    logic [31:0] ref_regs [32];
    logic [31:0] ref_mem [1024];
    bit          ref_mem_valid [1024];

    async_mem_reg_file dut (
        .clk            (clk),
        .reset          (reset),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .rf_write       (rf_write),
        .rf_wr          (rf_wr),
        .rf_wd          (rf_wd),
        .rf_rr1         (rf_rr1),
        .rf_rr2         (rf_rr2),
        .rf_rd1         (rf_rd1),
        .rf_rd2         (rf_rd2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the model and count it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's worth of inputs away from the rising edge, then settle.
    task automatic applyStimulus(input logic rst, input logic m_we, input logic [31:0] m_addr,
                                 input logic [31:0] m_wd, input logic r_we, input logic [4:0] r_wr,
                                 input logic [31:0] r_wd, input logic [4:0] r_rr1,
                                 input logic [4:0] r_rr2);
        @(negedge clk);
        reset          = rst;
        mem_write      = m_we;
        mem_address    = m_addr;
        mem_write_data = m_wd;
        rf_write       = r_we;
        rf_wr          = r_wr;
        rf_wd          = r_wd;
        rf_rr1         = r_rr1;
        rf_rr2         = r_rr2;
        #1;
    endtask

    // Expected register read value under the current inputs and model state.
    function automatic logic [31:0] expectedRead(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef RF_BYPASS_EN
        if (rf_write && rf_wr != 5'd0 && rf_wr == idx) return rf_wd;
`endif
        return ref_regs[idx];
    endfunction

    // Advance through the rising edge and apply the same effect to the model.
    task automatic clockEdge();
        int widx;
        widx = int'(mem_address / 4) % 1024;
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        end else begin
            if (rf_write && rf_wr != 5'd0) ref_regs[rf_wr] = rf_wd;
            if (mem_write) begin
                ref_mem[widx]       = mem_write_data;
                ref_mem_valid[widx] = 1'b1;
            end
        end
    endtask

    // Check both register read ports and, where the word is known, the memory port.
    task automatic checkAll(input string tag);
        int widx;
        widx = int'(mem_address / 4) % 1024;
        checkOutput({tag, "_rd1"}, rf_rd1, expectedRead(rf_rr1));
        checkOutput({tag, "_rd2"}, rf_rd2, expectedRead(rf_rr2));
        if (ref_mem_valid[widx]) checkOutput({tag, "_mem"}, mem_read_data, ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] rnd_addr;
        logic [31:0] upper;
        int          word;
        logic        do_rst;

        check_count = 0;
        error_count = 0;
        for (int i = 0; i < 32; i++) ref_regs[i] = 32'h0;
        for (int i = 0; i < 1024; i++) begin
            ref_mem[i]       = 32'h0;
            ref_mem_valid[i] = 1'b0;
        end

        // Reset for one edge, then both ports read zero.
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd31);
        checkOutput("reset_rd1_r7", rf_rd1, 32'h0);
        checkOutput("reset_rd2_r31", rf_rd2, 32'h0);

        // Register write then read on both ports.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        checkOutput("rf_rd1_r5", rf_rd1, 32'hDEADBEEF);
        checkOutput("rf_rd2_r5", rf_rd2, 32'hDEADBEEF);

        // Writes to register 0 are discarded.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd0, 32'h12345678, 5'd3, 5'd4);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("r0_rd1", rf_rd1, 32'h0);
        checkOutput("r0_rd2", rf_rd2, 32'h0);

        // Memory write, low-bit and wrap-around reads.
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("mem_low_bits", mem_read_data, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b0, 32'h0000_1010, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("mem_wrap", mem_read_data, 32'hCAFEF00D);

        // Memory write before the edge shows old value, after shows new.
        applyStimulus(1'b1, 1'b1, 32'h0000_0020, 32'h11111111, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b1, 32'h0000_0010, 32'h0BADF00D, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("mem_old_before_edge", mem_read_data, 32'hCAFEF00D);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        checkOutput("mem_new_after_edge", mem_read_data, 32'h0BADF00D);

        // Memory write suppressed during reset; reset also beats a register write.
        applyStimulus(1'b0, 1'b1, 32'h0000_0020, 32'h22222222, 1'b1, 5'd6, 32'h77777777, 5'd0, 5'd0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
        checkOutput("mem_reset_suppress", mem_read_data, 32'h11111111);
        checkOutput("reset_clears_r5", rf_rd1, 32'h0);
        checkOutput("reset_beats_write_r6", rf_rd2, 32'h0);

        // Same-cycle write and read of register 9.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9);
`ifdef RF_BYPASS_EN
        checkOutput("r9_before_edge", rf_rd1, 32'hA5A5A5A5);
`else
        checkOutput("r9_before_edge", rf_rd1, 32'h0);
`endif
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
        checkOutput("r9_after_edge", rf_rd1, 32'hA5A5A5A5);

        // Randomized traffic against the model on a small set of memory words.
        for (int n = 0; n < 400; n++) begin
            upper    = $urandom;
            word     = (($urandom % 2) != 0) ? (1008 + int'($urandom % 16)) : int'($urandom % 16);
            rnd_addr = {upper[31:12], 10'(word), upper[1:0]};
            do_rst   = (($urandom % 40) == 0);
            applyStimulus(!do_rst, (($urandom % 3) == 0), rnd_addr, $urandom,
                          (!do_rst && (($urandom % 2) == 0)), 5'($urandom), $urandom,
                          5'($urandom), 5'($urandom));
            checkAll("rand");
            clockEdge();
        end

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
